aes256_rk_sched_ctrl: RTL and testbench
=======================================

Name: aes256_rk_sched_ctrl

Overview:
- Sequences the single-round AES-256 key expansion stage and owns its round counter.
- Captures the 15 round keys it produces into a local key store, then serves them to the cipher datapath by round index, in encrypt or decrypt order.
- Sits directly downstream of the key expansion stage, which it also drives, and upstream of the round datapath.
- The expansion stage always runs forward (exp_inv_en = 0); decrypt order is obtained by reversed reads.

Parameters:
- KEY_W, 256, cipher key width.
- RK_W, 128, round key width.
- NUM_RK, 15, number of round keys (AES-256).
- EXP_LAT, 1, cycles from presenting exp_round = r to round key r being valid on exp_round_key.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; begins expansion of key_in.
- key_in  input  KEY_W  cipher key; sampled on the start cycle.
- exp_key  output  KEY_W  latched key, driven to the expansion stage key_in.
- exp_round  output  4  round index driven to the expansion stage.
- exp_inv_en  output  1  constant 0.
- exp_round_key  input  RK_W  round key from the expansion stage.
- busy  output  1  expansion in progress.
- keys_ready  output  1  all NUM_RK keys are stored and valid.
- rk_req  input  1  read request.
- rk_idx  input  4  cipher round number, 0..14.
- rk_decrypt  input  1  1 = reverse order: physical index = 14 - rk_idx.
- rk_valid  output  1  read data valid.
- rk_data  output  RK_W  read data.

Behaviour:
- Reset (synchronous, wins over every other input):
  - FSM goes to IDLE; issue and capture counters go to 0; capture pipeline is cleared.
  - exp_key, exp_round, busy, keys_ready, rk_valid and rk_data go to 0.
  - All key-store entries go to 0.
  - Reset during EXPAND aborts the expansion; no partial keys_ready.
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - start: latch key_in into exp_key, issue count = 0, go to EXPAND.
  - No start: exp_round holds 0.
- EXPAND:
  - busy = 1; exp_round = issue count, which increments by 1 per cycle up to 14, then holds 14.
  - Issue valid/index goes through an EXP_LAT-deep shift pipeline.
  - When the pipeline output is valid with index i, store[i] <= exp_round_key.
  - When i = 14 is captured: next state DONE, keys_ready = 1 and busy = 0 from the following cycle.
  - start is ignored in this state.
- DONE:
  - keys_ready = 1; exp_round = 0.
  - start: relatch key, keys_ready = 0 from the next cycle, go to EXPAND.
- Timing: start at cycle T gives exp_round = r at T+1+r. store[r] is written at the end of cycle T+1+r+EXP_LAT. keys_ready rises at T+16+EXP_LAT.
- Read port:
  - rk_req at cycle t produces rk_valid = 1 and rk_data at t+1, one register stage.
  - rk_valid = rk_req & keys_ready, sampled at t.
  - Physical index = rk_decrypt ? 14 - rk_idx : rk_idx.
  - rk_idx > 14: rk_valid = 1 and rk_data = 0.
  - Back-to-back requests every cycle are supported.
  - No rk_req, or keys_ready = 0: rk_valid = 0 and rk_data holds its previous value.
- Simultaneous events: a read in the same cycle as a DONE-state restart returns the old key, because keys_ready is still 1 at t. Reads after that cycle return rk_valid = 0 until the new keys_ready.
- Widths: the 4-bit counters wrap is not reachable, because the count saturates at 14.

Decomposition:
- Package aes_pkg holds:
  - constants KEY_W, RK_W, NUM_RK, RK_IDX_W = 4, LAST_RK = 14;
  - the FSM state encoding (IDLE, EXPAND, DONE);
  - the round-key type (RK_W-bit vector).
- Sub-module rk_store holds the 15 x RK_W register file:
  - synchronous write port (we, widx, wdata);
  - registered read port (re, ridx -> rdata; out-of-range ridx reads 0);
  - synchronous reset clear.
- The controller FSM, the capture pipeline and the order mapping stay in the top module.

Test Plan:
- FIPS-197 key 000102..1f, start pulse, bench model of the expansion stage with EXP_LAT = 1. Required:
  - keys_ready rises 17 cycles after start;
  - read idx 0 = 000102030405060708090a0b0c0d0e0f;
  - idx 1 = 101112131415161718191a1b1c1d1e1f;
  - idx 2 = a573c29fa176c498a97fce93a572c09c;
  - idx 14 = 24fc79ccbf0979e9371ac23c6d68de36.
- Same key, rk_decrypt = 1, rk_idx 0 then 14 back-to-back. Required: rk_data = 24fc79cc...de36, then 00010203...0f, with rk_valid high on both consecutive cycles.
- rk_req with rk_idx = 15 after keys_ready -> rk_valid = 1, rk_data = 0. rk_req before keys_ready -> rk_valid = 0.
- start pulses at cycles 3 and 8 of EXPAND -> ignored: exp_round sequence 0..14 is uninterrupted and exp_key is unchanged.
- rst asserted while exp_round = 7 -> next cycle: busy = 0, keys_ready = 0, exp_round = 0, and a read after a fresh expansion returns the correct new keys.
- In DONE, start with key all-ff -> keys_ready = 0 from the next cycle and rises 17 cycles after start. idx 0 = ffff...ff, and idx 2 matches the golden model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, types and helpers for the AES-256 round-key scheduler.
package aes_pkg;

  localparam int unsigned KEY_W    = 256;
  localparam int unsigned RK_W     = 128;
  localparam int unsigned NUM_RK   = 15;
  localparam int unsigned RK_IDX_W = 4;

  localparam logic [RK_IDX_W-1:0] LAST_RK = 4'd14;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  typedef logic [RK_W-1:0] rk_t;

  // Map a cipher round number to a key-store slot. Out-of-range rounds map to
  // slot 15, which the store reads back as zero.
  function automatic logic [RK_IDX_W-1:0] phys_idx(input logic [RK_IDX_W-1:0] idx,
                                                   input logic                decrypt);
    if (idx > LAST_RK) begin
      return '1;
    end else if (decrypt) begin
      return LAST_RK - idx;
    end else begin
      return idx;
    end
  endfunction

endpackage

// File: rtl/rk_store.sv
// 15-entry round-key register file with one write port and a registered read port.
module rk_store
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [RK_IDX_W-1:0] widx,
  input  rk_t                 wdata,
  input  logic                re,
  input  logic [RK_IDX_W-1:0] ridx,
  output rk_t                 rdata
);

  rk_t mem [NUM_RK];

  // Storage write, registered read; rdata holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_RK); i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we && (widx <= LAST_RK)) begin
        mem[widx] <= wdata;
      end
      if (re) begin
        rdata <= (ridx <= LAST_RK) ? mem[ridx] : '0;
      end
    end
  end

endmodule

// File: rtl/aes256_rk_sched_ctrl.sv
// Drives the AES-256 key expansion stage round by round, captures the 15 round
// keys it returns and serves them to the cipher datapath in either order.
module aes256_rk_sched_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned EXP_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_W-1:0]    key_in,
  output logic [KEY_W-1:0]    exp_key,
  output logic [RK_IDX_W-1:0] exp_round,
  output logic                exp_inv_en,
  input  logic [RK_W-1:0]     exp_round_key,
  output logic                busy,
  output logic                keys_ready,
  input  logic                rk_req,
  input  logic [RK_IDX_W-1:0] rk_idx,
  input  logic                rk_decrypt,
  output logic                rk_valid,
  output logic [RK_W-1:0]     rk_data
);

  state_e              state_q;
  logic                issue_done_q;
  logic [RK_IDX_W-1:0] cap_cnt_q;

  // Issue tracking pipeline, matched to the expansion stage latency.
  logic                pipe_vld_q [EXP_LAT];
  logic [RK_IDX_W-1:0] pipe_idx_q [EXP_LAT];

  logic                cap_we;
  logic [RK_IDX_W-1:0] cap_idx;
  logic                cap_last;
  logic                rd_en;
  logic [RK_IDX_W-1:0] rd_idx;

  // Expansion always runs forward; decrypt order comes from reversed reads.
  assign exp_inv_en = 1'b0;

  assign cap_idx  = pipe_idx_q[EXP_LAT-1];
  assign cap_we   = pipe_vld_q[EXP_LAT-1] && (state_q == StExpand);
  // Final key lands only once all earlier keys have been captured.
  assign cap_last = cap_we && (cap_idx == LAST_RK) && (cap_cnt_q == LAST_RK);

  assign rd_en  = rk_req & keys_ready;
  assign rd_idx = phys_idx(rk_idx, rk_decrypt);

  // Controller FSM with registered outputs to the expansion stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      exp_key      <= '0;
      exp_round    <= '0;
      busy         <= 1'b0;
      keys_ready   <= 1'b0;
      issue_done_q <= 1'b0;
      cap_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          exp_round <= '0;
          if (start) begin
            exp_key      <= key_in;
            busy         <= 1'b1;
            issue_done_q <= 1'b0;
            cap_cnt_q    <= '0;
            state_q      <= StExpand;
          end
        end
        StExpand: begin
          if (cap_we) begin
            cap_cnt_q <= cap_cnt_q + 4'd1;
          end
          if (exp_round == LAST_RK) begin
            issue_done_q <= 1'b1;
          end
          if (cap_last) begin
            exp_round  <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b1;
            state_q    <= StDone;
          end else if (exp_round != LAST_RK) begin
            exp_round <= exp_round + 4'd1;
          end
        end
        StDone: begin
          exp_round <= '0;
          if (start) begin
            exp_key      <= key_in;
            keys_ready   <= 1'b0;
            busy         <= 1'b1;
            issue_done_q <= 1'b0;
            cap_cnt_q    <= '0;
            state_q      <= StExpand;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Shift issued round indices so they line up with the returned round key.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(EXP_LAT); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= (state_q == StExpand) && !issue_done_q;
      pipe_idx_q[0] <= exp_round;
      for (int i = 1; i < int'(EXP_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // Read valid tracks the registered read data one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid <= 1'b0;
    end else begin
      rk_valid <= rd_en;
    end
  end

  rk_store u_rk_store (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_we),
    .widx  (cap_idx),
    .wdata (exp_round_key),
    .re    (rd_en),
    .ridx  (rd_idx),
    .rdata (rk_data)
  );

endmodule

// File: tb/tb_aes256_rk_sched_ctrl.sv
// Bench for aes256_rk_sched_ctrl: a behavioural AES-256 key expansion stage
// feeds the DUT; a scoreboard queue holds expected read data for the monitor.
module tb_aes256_rk_sched_ctrl;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] FF_KEY = {256{1'b1}};
  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1   = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K2   = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] K14  = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] FF0  = {128{1'b1}};
  localparam logic [127:0] FF2  = 128'he8e9e9e917161616e8e9e9e917161616;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] key_in;
  logic [255:0] exp_key;
  logic [3:0]   exp_round;
  logic         exp_inv_en;
  logic [127:0] exp_round_key = '0;
  logic         busy;
  logic         keys_ready;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_decrypt;
  logic         rk_valid;
  logic [127:0] rk_data;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  aes256_rk_sched_ctrl #(.EXP_LAT(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .key_in        (key_in),
    .exp_key       (exp_key),
    .exp_round     (exp_round),
    .exp_inv_en    (exp_inv_en),
    .exp_round_key (exp_round_key),
    .busy          (busy),
    .keys_ready    (keys_ready),
    .rk_req        (rk_req),
    .rk_idx        (rk_idx),
    .rk_decrypt    (rk_decrypt),
    .rk_valid      (rk_valid),
    .rk_data       (rk_data)
  );

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // FIPS-197 AES-256 key expansion, returning round key r.
  function automatic logic [127:0] model_rk(input logic [255:0] key, input logic [3:0] r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          b;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    if (r > 4'd14) return '0;
    b = 4 * int'(r);
    return {w[b], w[b+1], w[b+2], w[b+3]};
  endfunction

  // Expansion stage model, one cycle of latency.
  always @(posedge clk) exp_round_key <= model_rk(exp_key, exp_round);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every valid read pops and compares the next expected key.
  always @(negedge clk) begin
    if (rk_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rk_valid=1 data %0h, expected no pending read", rk_data);
      end else begin
        chk("rd_data", {128'h0, rk_data}, {128'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx, input logic dec, input logic [127:0] e);
    rk_req     = 1'b1;
    rk_idx     = idx;
    rk_decrypt = dec;
    exp_q.push_back(e);
    tick();
    rk_req     = 1'b0;
    rk_decrypt = 1'b0;
  endtask

  task automatic start_key(input logic [255:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Returns the cycle count (1 = cycle after start) at which keys_ready is seen.
  task automatic wait_ready(input int first, output int rc);
    rc = 0;
    for (int c = first; c <= 40; c++) begin
      @(negedge clk);
      if (keys_ready) begin
        rc = c;
        break;
      end
      tick();
    end
  endtask

  int ready_cyc;
  int rc;
  int found;

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0;
    rk_req = 1'b0; rk_idx = '0; rk_decrypt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_exp_key", exp_key, 256'h0);
    chk("rst_exp_round", exp_round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_data", rk_data, 0);
    chk("exp_inv_en", exp_inv_en, 0);

    // Read before any keys exist
    tick();
    rk_req = 1'b1; rk_idx = 4'd0;
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk("rd_before_ready_valid", rk_valid, 0);

    // Expansion with start pulses injected mid-run
    tick();
    start_key(FIPS_KEY);
    ready_cyc = 0;
    for (int cyc = 1; cyc <= 30 && ready_cyc == 0; cyc++) begin
      start  = (cyc == 4 || cyc == 9);
      key_in = start ? FF_KEY : FIPS_KEY;
      @(negedge clk);
      if (cyc <= 16) begin
        chk("exp_round_seq", exp_round, (cyc > 15) ? 14 : cyc - 1);
        chk("busy_expand", busy, 1);
        chk("exp_key_hold", exp_key, FIPS_KEY);
      end
      if (keys_ready) begin
        ready_cyc = cyc;
        chk("busy_after_ready", busy, 0);
      end
      tick();
    end
    start = 1'b0;
    chk("ready_latency", ready_cyc, 17);

    // Encrypt-order reads
    rd(4'd0, 1'b0, K0);
    rd(4'd1, 1'b0, K1);
    rd(4'd2, 1'b0, K2);
    rd(4'd14, 1'b0, K14);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rd_hold_valid", rk_valid, 0);
    chk("rd_hold_data", rk_data, K14);

    // Decrypt order, back-to-back
    tick();
    rk_req = 1'b1; rk_decrypt = 1'b1; rk_idx = 4'd0;
    exp_q.push_back(K14);
    tick();
    rk_idx = 4'd14;
    exp_q.push_back(K0);
    @(negedge clk);
    chk("b2b_valid0", rk_valid, 1);
    tick();
    rk_req = 1'b0; rk_decrypt = 1'b0;
    @(negedge clk);
    chk("b2b_valid1", rk_valid, 1);

    // Out-of-range round index
    tick();
    rd(4'd15, 1'b0, '0);
    @(negedge clk);
    chk("oor_valid", rk_valid, 1);
    rd(4'd15, 1'b1, '0);

    // Restart from DONE with a same-cycle read of the old keys
    tick();
    key_in = FF_KEY; start = 1'b1;
    rk_req = 1'b1; rk_idx = 4'd0; rk_decrypt = 1'b0;
    exp_q.push_back(K0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("restart_ready_low", keys_ready, 0);
    chk("restart_old_read_valid", rk_valid, 1);
    tick();
    rk_req = 1'b0;
    @(negedge clk);
    chk("rd_during_expand_valid", rk_valid, 0);
    tick();
    wait_ready(3, rc);
    chk("restart_latency", rc, 17);
    rd(4'd0, 1'b0, FF0);
    rd(4'd2, 1'b0, FF2);
    rd(4'd14, 1'b1, FF0);

    // Reset in the middle of an expansion
    tick();
    start_key(FIPS_KEY);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (exp_round == 4'd7) found = 1;
    end
    chk("abort_reach7", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_keys_ready", keys_ready, 0);
    chk("abort_exp_round", exp_round, 0);
    repeat (20) tick();
    @(negedge clk);
    chk("abort_no_ready", keys_ready, 0);

    // Fresh expansion after abort
    tick();
    start_key(FIPS_KEY);
    wait_ready(1, rc);
    chk("fresh_latency", rc, 17);
    rd(4'd2, 1'b0, K2);
    rd(4'd0, 1'b1, K14);
    rd(4'd13, 1'b1, K1);

    repeat (3) tick();
    @(negedge clk);
    chk("rd_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
